// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on valid/ready and emits them MSB-first on a registered x.
// Optional trailing odd-parity bit per word when SER_PARITY_EN is defined.
module serial_bit_feeder #(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic [15:0]      word_count
);

    localparam int unsigned CW = $clog2(WIDTH);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic [15:0]      word_count_q, word_count_d;
    logic             accept;
    logic             end_word;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        x_d          = x_q;
        x_valid_d    = x_valid_q;
        word_count_d = word_count_q;
        din_ready    = 1'b0;
        end_word     = 1'b0;
`ifdef SER_PARITY_EN
        parity_d     = parity_q;
`endif

        case (state_q)
            IDLE: begin
                din_ready = 1'b1;
            end
            SHIFT: begin
                if (bitcnt_q == '0) begin
`ifdef SER_PARITY_EN
                    state_d = PARITY;
                    x_d     = parity_q;
`else
                    din_ready = 1'b1;
                    end_word  = 1'b1;
`endif
                end else begin
                    // shreg keeps the pending bits left-aligned, so the next bit is always at WIDTH-2
                    shreg_d  = shreg_q << 1;
                    x_d      = shreg_q[WIDTH-2];
                    bitcnt_d = bitcnt_q - 1'b1;
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                din_ready = 1'b1;
                end_word  = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        accept = din_valid && din_ready;

        if (end_word) begin
            word_count_d = word_count_q + 16'd1;
            state_d      = IDLE;
            x_d          = IDLE_BIT;
            x_valid_d    = 1'b0;
        end

        // A new word loaded on the closing edge of the previous one follows with no gap
        if (accept) begin
            state_d   = SHIFT;
            shreg_d   = din;
            x_d       = din[WIDTH-1];
            x_valid_d = 1'b1;
            bitcnt_d  = CW'(WIDTH - 1);
`ifdef SER_PARITY_EN
            parity_d  = ~^din;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            x_q          <= IDLE_BIT;
            x_valid_q    <= 1'b0;
            word_count_q <= '0;
`ifdef SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            x_q          <= x_d;
            x_valid_q    <= x_valid_d;
            word_count_q <= word_count_d;
`ifdef SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign busy       = (state_q != IDLE);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Randomized self-checking bench for serial_bit_feeder against a bit-queue reference model.
module tb_serial_bit_feeder;

    localparam int unsigned W  = 8;
    localparam logic        IB = 1'b0;
`ifdef SER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         x;
    logic         x_valid;
    logic         busy;
    logic [15:0]  word_count;

    serial_bit_feeder #(.WIDTH(W), .IDLE_BIT(IB)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference: the bit on x now, plus the queue of bits still to come
    typedef struct {
        logic b;
        logic last;
    } sbit_t;

    sbit_t       pend[$];
    logic        cur_x;
    logic        cur_v;
    logic        cur_last;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return !cur_v || cur_last;
    endfunction

    task automatic model_reset();
        pend.delete();
        cur_v    = 1'b0;
        cur_x    = IB;
        cur_last = 1'b0;
        m_cnt    = '0;
    endtask

    task automatic model_edge(input logic acc, input logic [W-1:0] d);
        sbit_t s;
        if (cur_v && cur_last) m_cnt = m_cnt + 16'd1;
        if (acc) begin
            for (int i = W - 1; i >= 0; i--) begin
                s.b    = d[i];
                s.last = (i == 0) && !PAR;
                pend.push_back(s);
            end
            if (PAR) begin
                s.b    = ~^d;
                s.last = 1'b1;
                pend.push_back(s);
            end
        end
        if (pend.size() > 0) begin
            s        = pend.pop_front();
            cur_x    = s.b;
            cur_v    = 1'b1;
            cur_last = s.last;
        end else begin
            cur_x    = IB;
            cur_v    = 1'b0;
            cur_last = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("x",          x,          cur_x);
        check("x_valid",    x_valid,    cur_v);
        check("busy",       busy,       cur_v);
        check("din_ready",  din_ready,  exp_ready());
        check("word_count", word_count, m_cnt);
    endtask

    // Entered just after a falling edge; leaves at the next falling edge
    task automatic cycle(input logic v, input logic [W-1:0] d);
        logic r;
        din_valid = v;
        din       = d;
        check_outputs();
        r = exp_ready();
        @(posedge clk);
        model_edge(v && r, d);
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d);
        logic r;
        int unsigned n;
        n = 0;
        do begin
            r = exp_ready();
            cycle(1'b1, d);
            n++;
        end while (!r && n < 2 * W + 4);
        if (!r) check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, W'($urandom));
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        #3;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // single word
        send(8'h1B);
        idle(9);
        check("wc_single", word_count, 32'd1);

        // back-to-back with valid held
        send(8'h1B);
        send(8'hDB);
        idle(W + 3);

        // new din held while busy is ignored until the word's final cycle
        send(8'h1B);
        idle(2);
        send(8'hFF);
        idle(W + 3);

        // asynchronous reset mid-word
        send(8'hA5);
        idle(3);
        async_reset();
        check("wc_after_rst", word_count, 32'd0);
        send(8'h1B);
        idle(W + 3);

        // preload the counter near wrap; random traffic carries it through 0xFFFF -> 0x0000
        force dut.word_count_q = 16'hFFFD;
        #1 release dut.word_count_q;
        m_cnt = 16'hFFFD;
        @(negedge clk);

        for (int unsigned i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(0, 9) < 7, W'($urandom));
            end
        end
        idle(W + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
